digit_chain_counter: RTL and testbench
======================================

# digit_chain_counter

Parametrised cascade of modulo-N digit counters for the stopwatch datapath. It replaces the single-digit counters and their external rollover wiring with one block. Each digit has its own terminal value. The chain counts up or down, supports a parallel load and an optional saturate mode, and flags full-chain wrap with a one-cycle pulse. It sits between the tick prescaler, which drives Enable, and the display/BCD-to-segment path, which consumes Q.

## Interface
- DIGITS, 4, number of cascaded digits (1..8); digit 0 is least significant.
- DW, 4, bits per digit.
- MAX_VEC, 16'h5959, packed per-digit terminal value; digit i max = MAX_VEC[i*DW +: DW]. Legal per-field range is 1..2^DW-1. Default gives mm:ss.
- WRAP, 1, 1 = wrap at limits; 0 = saturate at all-max (up) / all-zero (down).

- clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; clears Q and Rollover.
- Enable  in  1  count qualifier; one step per cycle while high.
- Up  in  1  direction; 1 = increment, 0 = decrement.
- Load  in  1  synchronous parallel load of LoadVal.
- LoadVal  in  DIGITS*DW  load data, same packing as Q.
- Q  out  DIGITS*DW  registered count, digit i at Q[i*DW +: DW].
- Rollover  out  1  registered pulse: chain wrapped on the previous edge.
- AtMax  out  1  combinational: every digit equals its terminal value.
- AtZero  out  1  combinational: Q == 0.

## Operation
- Priority at each rising edge: Reset > Load > Enable > hold.
- Reset: Q <= 0 and Rollover <= 0. AtZero is 1 and AtMax is 0 after reset.
- Load: each digit takes min(LoadVal field, its MAX field), so out-of-range fields clamp to max. Rollover <= 0. Enable is ignored that cycle.
- Up count, Enable = 1:
  - Digit 0 steps every enabled cycle.
  - Digit i steps only when digits 0..i-1 are all at their max.
  - A stepping digit at max goes to 0; otherwise it goes to value+1.
- Down count, Enable = 1:
  - Digit i steps only when digits 0..i-1 are all 0.
  - A stepping digit at 0 goes to its max; otherwise it goes to value-1.
- Full-chain wrap means up with AtMax = 1, or down with AtZero = 1.
  - WRAP = 1: Q wraps to all-zero (up) or all-max (down), and Rollover <= 1.
  - WRAP = 0: Q holds and Rollover <= 0, so the chain sticks at its limit.
- Any cycle that is not a wrap step (including Enable = 0 and hold) sets Rollover <= 0. Rollover is never stuck high.
- Up may change on any cycle. The new direction applies from that edge; there is no pipeline to flush.
- Digit values are always in 0..max. There is no illegal-state recovery path, because Load clamps.
- Rollover chains into a downstream counter's Enable with one cycle of latency.

## Timing
- Q latency: 1 cycle from the qualifying edge. No combinational path from inputs to Q or Rollover.
- Rollover is high exactly in the cycle Q first shows the wrapped value, and lasts one cycle per wrap.
- AtMax/AtZero are decoded from Q only, and valid in the same cycle as Q.
- Continuous Enable, up, default parameters: a full cycle is 3600 steps (60 min x 60 s). Rollover pulses every 3600 cycles.
- Reset asserted mid-count: Q = 0 on the next edge regardless of Load/Enable. Rollover = 0 on that edge even if a wrap coincided.
- Load and Enable high together: the load wins and no step occurs.

## Test plan
- Reset, then Enable = 1, Up = 1 for 10 cycles -> Q = 16'h0010 (digit0 9->0 carries digit1); Rollover stays 0.
- Load 16'h5958, Enable, Up = 1 -> Q = 16'h5959 with AtMax = 1, then Q = 16'h0000 with Rollover = 1 for exactly one cycle.
- From Q = 0, Enable, Up = 0 -> Q = 16'h5959 and Rollover = 1. Next step -> 16'h5958 and Rollover = 0.
- WRAP = 0, load 16'h5959, Enable, Up = 1 for 5 cycles -> Q holds 16'h5959 and Rollover never asserts. Then Up = 0 -> Q = 16'h5958.
- Load 16'hFFFF -> Q = 16'h5959 (clamped). Load and Enable in the same cycle -> Q = LoadVal exactly, with no step.
- Reset asserted in the same cycle as a wrap step (Q = 16'h5959, Enable = 1) -> Q = 0 and Rollover = 0 next cycle.

Source files
------------

// File: rtl/digit_chain_counter.sv
// digit_chain_counter: cascade of modulo-N digit counters with per-digit
// terminal values, up/down counting, clamped parallel load, optional
// saturation at the chain limits and a one-cycle full-chain wrap pulse.

// Per-digit combinational slice: limit decode, next value when stepping,
// and clamping of a load value to this digit's terminal value.
module digit_chain_cell #(
    parameter int          DW   = 4,
    parameter logic [DW-1:0] MAXD = '1
) (
    input  logic [DW-1:0] q,
    input  logic [DW-1:0] ld_val,
    input  logic          step,
    input  logic          up,
    output logic [DW-1:0] nxt,
    output logic [DW-1:0] ld_clamped,
    output logic          at_max,
    output logic          at_zero
);

    assign at_max  = (q == MAXD);
    assign at_zero = (q == '0);

    // Out-of-range load fields saturate to the terminal value, so the
    // register never holds a digit above its max.
    assign ld_clamped = (ld_val > MAXD) ? MAXD : ld_val;

    // Step the digit: up wraps max->0, down wraps 0->max.
    always_comb begin
        nxt = q;
        if (step) begin
            if (up) nxt = at_max  ? '0   : q + DW'(1);
            else    nxt = at_zero ? MAXD : q - DW'(1);
        end
    end

endmodule

module digit_chain_counter #(
    parameter int                     DIGITS  = 4,
    parameter int                     DW      = 4,
    parameter logic [DIGITS*DW-1:0]   MAX_VEC = 16'h5959,
    parameter bit                     WRAP    = 1'b1
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 Up,
    input  logic                 Load,
    input  logic [DIGITS*DW-1:0] LoadVal,
    output logic [DIGITS*DW-1:0] Q,
    output logic                 Rollover,
    output logic                 AtMax,
    output logic                 AtZero
);

    logic [DIGITS-1:0][DW-1:0] q_r;
    logic [DIGITS-1:0][DW-1:0] q_nxt;
    logic [DIGITS-1:0][DW-1:0] ld_arr;
    logic [DIGITS-1:0][DW-1:0] ld_clamped;
    logic [DIGITS-1:0]         at_max_d;
    logic [DIGITS-1:0]         at_zero_d;
    logic [DIGITS-1:0]         carry_up;
    logic [DIGITS-1:0]         carry_dn;
    logic [DIGITS-1:0]         step;
    logic                      chain_wrap;
    logic                      rollover_r;

    assign ld_arr = LoadVal;

    // Digit i steps when all lower digits sit at their limit for the
    // current direction; digit 0 always steps.
    assign carry_up[0] = 1'b1;
    assign carry_dn[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            if (i > 0) begin : g_carry
                assign carry_up[i] = carry_up[i-1] & at_max_d[i-1];
                assign carry_dn[i] = carry_dn[i-1] & at_zero_d[i-1];
            end
            assign step[i] = Up ? carry_up[i] : carry_dn[i];

            digit_chain_cell #(
                .DW   (DW),
                .MAXD (MAX_VEC[i*DW +: DW])
            ) u_cell (
                .q          (q_r[i]),
                .ld_val     (ld_arr[i]),
                .step       (step[i]),
                .up         (Up),
                .nxt        (q_nxt[i]),
                .ld_clamped (ld_clamped[i]),
                .at_max     (at_max_d[i]),
                .at_zero    (at_zero_d[i])
            );
        end
    endgenerate

    assign AtMax  = &at_max_d;
    assign AtZero = &at_zero_d;

    // The natural carry cascade already produces all-zero (up) or all-max
    // (down) on a full-chain wrap; saturate mode just suppresses that step.
    assign chain_wrap = Up ? AtMax : AtZero;

    // Count register and wrap pulse: Reset > Load > Enable > hold.
    always_ff @(posedge clk) begin
        if (Reset) begin
            q_r        <= '0;
            rollover_r <= 1'b0;
        end else if (Load) begin
            q_r        <= ld_clamped;
            rollover_r <= 1'b0;
        end else if (Enable) begin
            if (!(chain_wrap && !WRAP)) q_r <= q_nxt;
            rollover_r <= chain_wrap && WRAP;
        end else begin
            rollover_r <= 1'b0;
        end
    end

    assign Q        = q_r;
    assign Rollover = rollover_r;

endmodule

// File: tb/tb_digit_chain_counter.sv
// Directed bench for digit_chain_counter: a wrapping instance and a
// saturating instance share the same stimulus.
module tb_digit_chain_counter;

    logic        clk = 1'b0;
    logic        Reset, Enable, Up, Load;
    logic [15:0] LoadVal;
    logic [15:0] Q, Q2;
    logic        Rollover, Rollover2, AtMax, AtMax2, AtZero, AtZero2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    digit_chain_counter #(.DIGITS(4), .DW(4), .MAX_VEC(16'h5959), .WRAP(1'b1)) dut (
        .clk(clk), .Reset(Reset), .Enable(Enable), .Up(Up), .Load(Load),
        .LoadVal(LoadVal), .Q(Q), .Rollover(Rollover), .AtMax(AtMax), .AtZero(AtZero)
    );

    digit_chain_counter #(.DIGITS(4), .DW(4), .MAX_VEC(16'h5959), .WRAP(1'b0)) dut_sat (
        .clk(clk), .Reset(Reset), .Enable(Enable), .Up(Up), .Load(Load),
        .LoadVal(LoadVal), .Q(Q2), .Rollover(Rollover2), .AtMax(AtMax2), .AtZero(AtZero2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Reset = 0; Enable = 0; Up = 1; Load = 0; LoadVal = 16'h0000;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1; Enable = 1; Load = 1; LoadVal = 16'h1234;
        tick();
        idle();
        total++; if (Q !== 16'h0000) begin bad++; $display("FAIL reset_q got=%h exp=0000", Q); end
        total++; if (Rollover !== 1'b0) begin bad++; $display("FAIL reset_roll got=%b exp=0", Rollover); end
        total++; if (AtZero !== 1'b1) begin bad++; $display("FAIL reset_atzero got=%b exp=1", AtZero); end
        total++; if (AtMax !== 1'b0) begin bad++; $display("FAIL reset_atmax got=%b exp=0", AtMax); end
        total++; if (Q2 !== 16'h0000) begin bad++; $display("FAIL reset_q_sat got=%h exp=0000", Q2); end
    endtask

    task automatic test_count_up();
        int roll_seen = 0;
        Enable = 1; Up = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (Rollover !== 1'b0) roll_seen++;
        end
        Enable = 0;
        total++; if (Q !== 16'h0010) begin bad++; $display("FAIL count_up_q got=%h exp=0010", Q); end
        total++; if (roll_seen !== 0) begin bad++; $display("FAIL count_up_roll got=%0d exp=0", roll_seen); end
    endtask

    task automatic test_borrow_down();
        Load = 1; LoadVal = 16'h0100;
        tick();
        Load = 0; Enable = 1; Up = 0;
        tick();
        Enable = 0;
        total++; if (Q !== 16'h0059) begin bad++; $display("FAIL borrow_down got=%h exp=0059", Q); end
    endtask

    task automatic test_wrap_up();
        Load = 1; LoadVal = 16'h5958;
        tick();
        Load = 0; Enable = 1; Up = 1;
        tick();
        total++; if (Q !== 16'h5959) begin bad++; $display("FAIL wrap_up_pre got=%h exp=5959", Q); end
        total++; if (AtMax !== 1'b1) begin bad++; $display("FAIL wrap_up_atmax got=%b exp=1", AtMax); end
        total++; if (Rollover !== 1'b0) begin bad++; $display("FAIL wrap_up_pre_roll got=%b exp=0", Rollover); end
        tick();
        total++; if (Q !== 16'h0000) begin bad++; $display("FAIL wrap_up_q got=%h exp=0000", Q); end
        total++; if (Rollover !== 1'b1) begin bad++; $display("FAIL wrap_up_roll got=%b exp=1", Rollover); end
        Enable = 0;
        tick();
        total++; if (Rollover !== 1'b0) begin bad++; $display("FAIL wrap_up_pulse got=%b exp=0", Rollover); end
        total++; if (Q !== 16'h0000) begin bad++; $display("FAIL wrap_up_hold got=%h exp=0000", Q); end
    endtask

    task automatic test_wrap_down();
        Enable = 1; Up = 0;
        tick();
        total++; if (Q !== 16'h5959) begin bad++; $display("FAIL wrap_dn_q got=%h exp=5959", Q); end
        total++; if (Rollover !== 1'b1) begin bad++; $display("FAIL wrap_dn_roll got=%b exp=1", Rollover); end
        tick();
        total++; if (Q !== 16'h5958) begin bad++; $display("FAIL wrap_dn_next got=%h exp=5958", Q); end
        total++; if (Rollover !== 1'b0) begin bad++; $display("FAIL wrap_dn_next_roll got=%b exp=0", Rollover); end
        Enable = 0;
    endtask

    task automatic test_saturate();
        int roll_seen = 0;
        Load = 1; LoadVal = 16'h5959;
        tick();
        Load = 0; Enable = 1; Up = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (Rollover2 !== 1'b0) roll_seen++;
        end
        total++; if (Q2 !== 16'h5959) begin bad++; $display("FAIL sat_up_q got=%h exp=5959", Q2); end
        total++; if (roll_seen !== 0) begin bad++; $display("FAIL sat_up_roll got=%0d exp=0", roll_seen); end
        Up = 0;
        tick();
        total++; if (Q2 !== 16'h5958) begin bad++; $display("FAIL sat_dir_change got=%h exp=5958", Q2); end
        Enable = 0; Load = 1; LoadVal = 16'h0000;
        tick();
        Load = 0; Enable = 1; Up = 0;
        tick(); tick();
        total++; if (Q2 !== 16'h0000) begin bad++; $display("FAIL sat_dn_q got=%h exp=0000", Q2); end
        total++; if (Rollover2 !== 1'b0) begin bad++; $display("FAIL sat_dn_roll got=%b exp=0", Rollover2); end
        Enable = 0;
    endtask

    task automatic test_load();
        Load = 1; LoadVal = 16'hFFFF;
        tick();
        total++; if (Q !== 16'h5959) begin bad++; $display("FAIL load_clamp_all got=%h exp=5959", Q); end
        LoadVal = 16'h0A09;
        tick();
        total++; if (Q !== 16'h0909) begin bad++; $display("FAIL load_clamp_field got=%h exp=0909", Q); end
        LoadVal = 16'h1234; Enable = 1; Up = 1;
        tick();
        total++; if (Q !== 16'h1234) begin bad++; $display("FAIL load_vs_enable got=%h exp=1234", Q); end
        total++; if (Rollover !== 1'b0) begin bad++; $display("FAIL load_roll got=%b exp=0", Rollover); end
        Load = 0; Enable = 0;
    endtask

    task automatic test_reset_on_wrap();
        Load = 1; LoadVal = 16'h5959;
        tick();
        Load = 0; Enable = 1; Up = 1; Reset = 1;
        tick();
        Reset = 0; Enable = 0;
        total++; if (Q !== 16'h0000) begin bad++; $display("FAIL reset_wrap_q got=%h exp=0000", Q); end
        total++; if (Rollover !== 1'b0) begin bad++; $display("FAIL reset_wrap_roll got=%b exp=0", Rollover); end
    endtask

    task automatic test_full_cycle();
        int pulses = 0;
        int first  = -1;
        Reset = 1;
        tick();
        Reset = 0; Enable = 1; Up = 1;
        for (int k = 1; k <= 3600; k++) begin
            tick();
            if (Rollover === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        Enable = 0;
        total++; if (pulses !== 1) begin bad++; $display("FAIL full_cycle_pulses got=%0d exp=1", pulses); end
        total++; if (first !== 3600) begin bad++; $display("FAIL full_cycle_when got=%0d exp=3600", first); end
        total++; if (Q !== 16'h0000) begin bad++; $display("FAIL full_cycle_q got=%h exp=0000", Q); end
    endtask

    initial begin
        idle();
        test_reset();
        test_count_up();
        test_borrow_down();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load();
        test_reset_on_wrap();
        test_full_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
